// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect target selection and IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic [2:0]       JumpFlag,
  input  logic [31:0]      JrAddr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      PC,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      PC_plus4_id,
  output logic             valid_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0]      PC_STEP = 32'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic        redirect;
  logic        unused_jr_lsbs;

  // Fetch address comes straight from the PC register, no input path.
  assign imem_addr  = PC;
  assign pc_plus4   = PC + PC_STEP;
  assign branch_off = {{14{Instruction_id[15]}}, Instruction_id[15:0], 2'b00};
  assign redirect   = |JumpFlag;

  // Word alignment drops the two low bits of the jr register value.
  assign unused_jr_lsbs = ^JrAddr[1:0];

  // Redirect target, priority jr > j > branch.
  always_comb begin
    target = pc_plus4;
    if (JumpFlag[2]) begin
      target = {JrAddr[31:2], 2'b00};
    end else if (JumpFlag[1]) begin
      target = {PC_plus4_id[31:28], Instruction_id[25:0], 2'b00};
    end else if (JumpFlag[0]) begin
      target = PC_plus4_id + branch_off;
    end
  end

  // PC and IF/ID register: stall holds, redirect flushes, otherwise advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC             <= {RESET_PC[31:2], 2'b00};
      Instruction_id <= NOP_INSTR;
      PC_plus4_id    <= 32'd0;
      valid_id       <= 1'b0;
    end else if (Stall) begin
      PC             <= PC;
      Instruction_id <= Instruction_id;
      PC_plus4_id    <= PC_plus4_id;
      valid_id       <= valid_id;
    end else if (redirect) begin
      PC             <= target;
      Instruction_id <= NOP_INSTR;
      PC_plus4_id    <= 32'd0;
      valid_id       <= 1'b0;
    end else begin
      PC             <= pc_plus4;
      Instruction_id <= imem_data;
      PC_plus4_id    <= pc_plus4;
      valid_id       <= 1'b1;
    end
  end

  // Saturating event counters for stalled cycles and taken redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (Stall) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else if (redirect) begin
      if (flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus queues expectations, a monitor drains and compares them.
module tb_if_stage;

  localparam int F_PC    = 0;
  localparam int F_ADDR  = 1;
  localparam int F_INSTR = 2;
  localparam int F_PC4   = 3;
  localparam int F_VALID = 4;
  localparam int F_SCNT  = 5;
  localparam int F_FCNT  = 6;
  localparam int F_PC2   = 7;
  localparam int F_SCNT2 = 8;
  localparam int F_FCNT2 = 9;

  typedef struct {
    int          f;
    logic [31:0] v;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, Stall;
  logic [2:0]  JumpFlag;
  logic [31:0] JrAddr, imem_data, imem_addr, PC, Instruction_id, PC_plus4_id;
  logic        valid_id;
  logic [15:0] stall_cnt, flush_cnt;

  logic        reset2, stall2;
  logic [2:0]  jf2;
  logic [31:0] jr2, imem_data2, imem_addr2, pc2, instr2, pc4_2;
  logic        valid2;
  logic [1:0]  scnt2, fcnt2;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event check_now;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .JumpFlag(JumpFlag), .JrAddr(JrAddr),
    .imem_data(imem_data), .imem_addr(imem_addr), .PC(PC), .Instruction_id(Instruction_id),
    .PC_plus4_id(PC_plus4_id), .valid_id(valid_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .Stall(stall2), .JumpFlag(jf2), .JrAddr(jr2),
    .imem_data(imem_data2), .imem_addr(imem_addr2), .PC(pc2), .Instruction_id(instr2),
    .PC_plus4_id(pc4_2), .valid_id(valid2), .stall_cnt(scnt2), .flush_cnt(fcnt2)
  );

  // Instruction memory: word n = 0x1000_0000 + n, with a beq at 0x1C and a j at 0x3000_000C.
  always_comb begin
    case (imem_addr)
      32'h0000_001C: imem_data = 32'h1000_FFFE;
      32'h3000_000C: imem_data = 32'h0800_0040;
      default:       imem_data = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
    endcase
  end
  assign imem_data2 = 32'hDEAD_0000;

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_PC:    return PC;
      F_ADDR:  return imem_addr;
      F_INSTR: return Instruction_id;
      F_PC4:   return PC_plus4_id;
      F_VALID: return {31'd0, valid_id};
      F_SCNT:  return {16'd0, stall_cnt};
      F_FCNT:  return {16'd0, flush_cnt};
      F_PC2:   return pc2;
      F_SCNT2: return {30'd0, scnt2};
      F_FCNT2: return {30'd0, fcnt2};
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  // Monitor: drains queued expectations at each falling edge or on demand.
  initial begin
    forever begin
      @(negedge clk or check_now);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = q.pop_front();
        a = actual(e.f);
        n_checks++;
        if (a === e.v) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.tag, a, e.v);
      end
    end
  end

  task automatic expect_v(input int f, input logic [31:0] v, input string tag);
    exp_t e;
    e.f = f; e.v = v; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk_state(input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v, input string tag);
    expect_v(F_PC,    pc,          {tag, ".pc"});
    expect_v(F_ADDR,  pc,          {tag, ".imem_addr"});
    expect_v(F_INSTR, ins,         {tag, ".instr"});
    expect_v(F_PC4,   p4,          {tag, ".pc4"});
    expect_v(F_VALID, {31'd0, v},  {tag, ".valid"});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; JumpFlag = 3'b000; JrAddr = 32'd0;
    reset2 = 1'b1; stall2 = 1'b0; jf2 = 3'b000; jr2 = 32'd0;

    step(); step();
    chk_state(32'h0, 32'h0, 32'h0, 1'b0, "reset");
    expect_v(F_SCNT, 32'd0, "reset.scnt");
    expect_v(F_FCNT, 32'd0, "reset.fcnt");
    reset = 1'b0;

    step(); chk_state(32'h04, 32'h1000_0000, 32'h04, 1'b1, "fetch0");
    step(); chk_state(32'h08, 32'h1000_0001, 32'h08, 1'b1, "fetch1");
    step(); chk_state(32'h0C, 32'h1000_0002, 32'h0C, 1'b1, "fetch2");
    step(); chk_state(32'h10, 32'h1000_0003, 32'h10, 1'b1, "fetch3");

    Stall = 1'b1; JumpFlag = 3'b010;
    repeat (3) begin
      step(); chk_state(32'h10, 32'h1000_0003, 32'h10, 1'b1, "stall");
    end
    expect_v(F_SCNT, 32'd3, "stall.scnt");
    expect_v(F_FCNT, 32'd0, "stall.fcnt");
    Stall = 1'b0; JumpFlag = 3'b000;

    step(); step(); step(); step();
    chk_state(32'h20, 32'h1000_FFFE, 32'h20, 1'b1, "beq_fetch");
    JumpFlag = 3'b001;
    step(); chk_state(32'h18, 32'h0, 32'h0, 1'b0, "branch");
    expect_v(F_FCNT, 32'd1, "branch.fcnt");
    JumpFlag = 3'b000;
    step(); chk_state(32'h1C, 32'h1000_0006, 32'h1C, 1'b1, "after_branch");

    JumpFlag = 3'b100; JrAddr = 32'h3000_000C;
    step(); chk_state(32'h3000_000C, 32'h0, 32'h0, 1'b0, "jr_far");
    expect_v(F_FCNT, 32'd2, "jr_far.fcnt");
    JumpFlag = 3'b000;
    step(); chk_state(32'h3000_0010, 32'h0800_0040, 32'h3000_0010, 1'b1, "j_fetch");
    JumpFlag = 3'b011;
    step(); chk_state(32'h3000_0100, 32'h0, 32'h0, 1'b0, "j_over_branch");
    expect_v(F_FCNT, 32'd3, "j.fcnt");
    JumpFlag = 3'b111; JrAddr = 32'h0000_0207;
    step(); chk_state(32'h0000_0204, 32'h0, 32'h0, 1'b0, "jr_over_all");
    expect_v(F_FCNT, 32'd4, "jr.fcnt");
    JumpFlag = 3'b000;
    step(); chk_state(32'h208, 32'h1000_0081, 32'h208, 1'b1, "after_jr");

    JumpFlag = 3'b100; JrAddr = 32'h40;
    step(); expect_v(F_PC, 32'h40, "to40.pc");
    expect_v(F_FCNT, 32'd5, "to40.fcnt");
    JumpFlag = 3'b000; Stall = 1'b1;
    step(); expect_v(F_PC, 32'h40, "stall40.pc");
    expect_v(F_SCNT, 32'd4, "stall40.scnt");

    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk_state(32'h0, 32'h0, 32'h0, 1'b0, "async_reset");
    expect_v(F_SCNT, 32'd0, "async_reset.scnt");
    expect_v(F_FCNT, 32'd0, "async_reset.fcnt");
    ->check_now;
    step();
    reset = 1'b0; Stall = 1'b0;

    step(); expect_v(F_PC2, 32'hFFFF_FFF8, "wrap.reset_pc");
    reset2 = 1'b0;
    step(); expect_v(F_PC2, 32'hFFFF_FFFC, "wrap.pc1");
    step(); expect_v(F_PC2, 32'h0000_0000, "wrap.pc2");
    stall2 = 1'b1;
    repeat (4) step();
    expect_v(F_SCNT2, 32'd3, "sat.scnt");
    expect_v(F_PC2,   32'h0, "sat.pc_hold");
    stall2 = 1'b0; jf2 = 3'b100; jr2 = 32'h0000_0123;
    repeat (4) step();
    expect_v(F_FCNT2, 32'd3, "sat.fcnt");
    expect_v(F_PC2,   32'h120, "jr_misaligned.pc");
    expect_v(F_SCNT2, 32'd3, "sat.scnt_hold");
    jf2 = 3'b000;

    @(negedge clk); @(negedge clk); #1;
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      n_checks += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU. Directly upstream of ID.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Applies the redirect that ID resolves (JumpFlag), computing branch and j targets from its own IF/ID contents.
- Honours the hazard-unit Stall and flushes the wrong-path instruction on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word inserted into IF/ID (sll $0,$0,0).
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Stall  in  1  load-use hazard from the hazard unit; holds IF and IF/ID.
- JumpFlag  in  3  redirect request from ID: [0]=branch taken, [1]=j/jal, [2]=jr.
- JrAddr  in  32  forwarded rs value for jr.
- imem_data  in  32  instruction word at imem_addr; combinational read, same cycle.
- imem_addr  out  32  byte address to instruction memory; equals PC.
- PC  out  32  current fetch PC.
- Instruction_id  out  32  IF/ID instruction.
- PC_plus4_id  out  32  IF/ID PC+4, used for the jal link and branch base.
- valid_id  out  1  IF/ID holds a real instruction (0 = bubble).
- stall_cnt  out  CNT_W  cycles spent stalled, saturating.
- flush_cnt  out  CNT_W  redirects taken, saturating.

Behaviour:
Reset (async, immediate, also mid-operation):
- PC=RESET_PC, Instruction_id=NOP_INSTR, PC_plus4_id=0, valid_id=0, stall_cnt=0, flush_cnt=0.
- First edge after reset deasserts fetches RESET_PC.

Each rising edge without reset, evaluated in priority order:
1. Stall=1:
   - PC, Instruction_id, PC_plus4_id and valid_id hold.
   - stall_cnt += 1, saturating at all-ones.
   - JumpFlag is ignored, because ID re-resolves once the stall clears.
2. JumpFlag != 0 (redirect):
   - PC <= target.
   - Instruction_id <= NOP_INSTR, PC_plus4_id <= 0, valid_id <= 0 (flush the wrong-path fetch).
   - flush_cnt += 1, saturating.
3. Otherwise:
   - PC <= PC+4.
   - Instruction_id <= imem_data, PC_plus4_id <= PC+4, valid_id <= 1.

Target selection (combinational, priority jr > j > branch):
- JumpFlag[2]: {JrAddr[31:2],2'b00}. Misaligned low bits are dropped.
- JumpFlag[1]: {PC_plus4_id[31:28], Instruction_id[25:0], 2'b00}.
- JumpFlag[0]: PC_plus4_id + {{14{Instruction_id[15]}}, Instruction_id[15:0], 2'b00}.

Arithmetic and outputs:
- All adds are 32-bit modulo 2^32: PC 32'hFFFF_FFFC + 4 wraps to 0, and branch offsets wrap likewise.
- PC[1:0] is always 2'b00.
- One-cycle latency from imem_data to Instruction_id.
- A taken redirect costs exactly one bubble.
- imem_addr is combinational from the PC register only, with no path from inputs.
- Counters never wrap; they stay at all-ones once saturated.

Test Plan:
- Reset: assert reset for 2 edges with RESET_PC=0, release, memory word n = 32'h1000_0000+n.
  - Required: PC goes 0,4,8,…
  - Required: Instruction_id = 0x1000_0000 one edge after PC=0, then 0x1000_0001; valid_id rises on the first fetch.
- Stall: run to PC=0x10, hold Stall=1 for 3 edges with JumpFlag=3'b010 driven.
  - Required: PC stays 0x10, Instruction_id is unchanged, stall_cnt=3, flush_cnt=0.
- Branch: Instruction_id=beq with offset 0xFFFE and PC_plus4_id=0x20, JumpFlag=3'b001.
  - Required: next PC=0x18, Instruction_id=0 and valid_id=0 for one cycle, flush_cnt increments.
- j plus priority: Instruction_id=j with target 0x0000040, PC_plus4_id=0x3000_0010, JumpFlag=3'b011.
  - Required: PC=0x3000_0100 (j beats branch).
  - Then JumpFlag=3'b111 with JrAddr=0x0000_0207: required PC=0x0000_0204.
- Wrap: force RESET_PC=32'hFFFF_FFF8.
  - Required: PC goes FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stall: assert reset between edges while Stall=1 and PC=0x40.
  - Required: PC=RESET_PC and valid_id=0 immediately, before the next edge; counters read 0.
